// File: rtl/time_set_ctrl_pkg.sv
// Shared state encoding, clamp limits and BCD helper for the time-set controller.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'b00,
        SET_HOURS   = 2'b01,
        SET_MINUTES = 2'b10
    } state_t;

    localparam logic [5:0] MAX_HOURS   = 6'd23;
    localparam logic [5:0] MAX_MINUTES = 6'd59;

    function automatic logic [5:0] clamp(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Repeated subtraction; six steps cover any 6-bit input.
    function automatic logic [7:0] bcd_split(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/time_set_ctrl_key_debounce.sv
// Pushbutton synchronizer + debouncer; press pulse lands DEBOUNCE_CYCLES+2 edges after the first low sample.
// No backpressure: the press pulse is a single-cycle strobe.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_key;
    logic          key_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_key  <= 1'b1;
            key_level <= 1'b1;
            key_prev  <= 1'b1;
            key_press <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= key_raw;
            sync_key  <= sync_meta;
            key_prev  <= key_level;
            key_press <= key_prev & ~key_level;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync_key == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_level <= sync_key;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set mode FSM: each debounced press steps RUN -> SET_HOURS -> SET_MINUTES -> RUN, emitting clamped BCD loads.
// Strobe and mode change appear DEBOUNCE_CYCLES+3 edges after the first low key sample; no backpressure.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic       CLK_50_MHZ_GEN,
    input  logic       Reset,
    input  logic       Time_Set,
    input  logic [9:4] SW,
    output logic       Run_Enable,
    output logic [1:0] Set_Mode,
    output logic       Load_Hours,
    output logic       Load_Minutes,
    output logic [3:0] Load_Tens,
    output logic [3:0] Load_Ones,
    output logic       Blink
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic          key_level;
    logic          key_press;
    logic          advance;
    state_t        state;
    logic [BW-1:0] blink_cnt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk      (CLK_50_MHZ_GEN),
        .rst_n    (Reset),
        .key_raw  (Time_Set),
        .key_level(key_level),
        .key_press(key_press)
    );

    // Only act on a press while the debounced key is still seen held.
    assign advance    = key_press & ~key_level;
    assign Run_Enable = (state == RUN);
    assign Set_Mode   = state;

    always_ff @(posedge CLK_50_MHZ_GEN) begin
        if (!Reset) begin
            state        <= RUN;
            Load_Hours   <= 1'b0;
            Load_Minutes <= 1'b0;
            Load_Tens    <= 4'd0;
            Load_Ones    <= 4'd0;
            Blink        <= 1'b0;
            blink_cnt    <= '0;
        end else begin
            Load_Hours   <= 1'b0;
            Load_Minutes <= 1'b0;
            if (advance) begin
                Blink     <= 1'b0;
                blink_cnt <= '0;
                case (state)
                    RUN: state <= SET_HOURS;
                    SET_HOURS: begin
                        state                  <= SET_MINUTES;
                        Load_Hours             <= 1'b1;
                        {Load_Tens, Load_Ones} <= bcd_split(clamp(SW, MAX_HOURS));
                    end
                    SET_MINUTES: begin
                        state                  <= RUN;
                        Load_Minutes           <= 1'b1;
                        {Load_Tens, Load_Ones} <= bcd_split(clamp(SW, MAX_MINUTES));
                    end
                    default: state <= RUN;
                endcase
            end else if (state != RUN) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    Blink     <= ~Blink;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                Blink     <= 1'b0;
                blink_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized + directed bench for time_set_ctrl against a run-length based reference model.
module tb_time_set_ctrl;

    localparam int D = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic [9:4] sw;
    logic       run_en;
    logic [1:0] mode;
    logic       lh;
    logic       lm;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blink;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .BLINK_CYCLES   (B)
    ) dut (
        .CLK_50_MHZ_GEN(clk),
        .Reset         (rst_n),
        .Time_Set      (key),
        .SW            (sw),
        .Run_Enable    (run_en),
        .Set_Mode      (mode),
        .Load_Hours    (lh),
        .Load_Minutes  (lm),
        .Load_Tens     (tens),
        .Load_Ones     (ones),
        .Blink         (blink)
    );

    int n_vec  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int sw_cur = 0;
    int last_t0;
    int lh_cyc, lm_cyc;
    logic [7:0] lh_val, lm_val;
    logic       lm_run;

    // Reference model state, expressed as raw-key run lengths and event times.
    int m_mode, m_tens, m_ones, m_entry;
    bit m_lh, m_lm, m_key_up;
    int low_run, high_run;
    int pend[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit k, input int s);
        int v;
        m_lh = 1'b0;
        m_lm = 1'b0;
        if (!r) begin
            m_mode = 0; m_tens = 0; m_ones = 0;
            m_key_up = 1'b1; low_run = 0; high_run = 0;
            pend.delete();
            return;
        end
        if (k) begin high_run++; low_run = 0; end
        else   begin low_run++;  high_run = 0; end
        // D consecutive low samples from a released key produce one press, seen D+3 edges after the first.
        if (m_key_up && !k && low_run == D) begin
            m_key_up = 1'b0;
            pend.push_back(cyc + 4);
        end else if (!m_key_up && k && high_run == D) begin
            m_key_up = 1'b1;
        end
        if (pend.size() > 0 && pend[0] == cyc) begin
            void'(pend.pop_front());
            case (m_mode)
                0: begin m_mode = 1; m_entry = cyc; end
                1: begin
                    v = min_i(s, 23);
                    m_lh = 1'b1; m_tens = v / 10; m_ones = v % 10;
                    m_mode = 2; m_entry = cyc;
                end
                default: begin
                    v = min_i(s, 59);
                    m_lm = 1'b1; m_tens = v / 10; m_ones = v % 10;
                    m_mode = 0;
                end
            endcase
        end
    endtask

    function automatic logic [31:0] model_outs();
        int b;
        b = (m_mode != 0) ? (((cyc - m_entry) / B) % 2) : 0;
        return 32'(((m_mode == 0) ? 1 : 0) << 13 | (m_mode << 11) | (int'(m_lh) << 10) |
                   (int'(m_lm) << 9) | (m_tens << 5) | (m_ones << 1) | b);
    endfunction

    task automatic tick(input bit r, input bit k);
        logic [31:0] obs;
        rst_n = r;
        key   = k;
        sw    = 6'(sw_cur);
        @(posedge clk);
        #1;
        cyc++;
        model_step(r, k, sw_cur);
        obs = 32'({run_en, mode, lh, lm, tens, ones, blink});
        chk("outs", obs, model_outs());
        chk("excl", 32'(lh & lm), 32'd0);
        if (lh) begin lh_cyc = cyc; lh_val = {tens, ones}; end
        if (lm) begin lm_cyc = cyc; lm_val = {tens, ones}; lm_run = run_en; end
    endtask

    task automatic press(input int len, input int gap);
        last_t0 = cyc + 1;
        repeat (len) tick(1'b1, 1'b0);
        repeat (gap) tick(1'b1, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; key = 1'b1; sw = '0;
        m_mode = 0; m_entry = 0; m_key_up = 1'b1;
        lh_cyc = -1; lm_cyc = -1; lh_val = '0; lm_val = '0; lm_run = 1'b0;

        repeat (3) tick(1'b0, 1'b1);
        repeat (20) tick(1'b1, 1'b1);
        chk("idle_mode", 32'(mode), 32'd0);
        chk("idle_run", 32'(run_en), 32'd1);

        // Hours 17, minutes 42 with exact strobe latency.
        sw_cur = 17;
        press(6, 14);
        lh_cyc = -1;
        press(6, 14);
        chk("lh_lat", 32'(lh_cyc - last_t0), 32'd7);
        chk("lh_val", 32'(lh_val), 32'h17);
        sw_cur = 42;
        lm_cyc = -1;
        press(6, 14);
        chk("lm_lat", 32'(lm_cyc - last_t0), 32'd7);
        chk("lm_val", 32'(lm_val), 32'h42);
        chk("lm_run", 32'(lm_run), 32'd1);

        // Clamping at 63.
        press(6, 14);
        sw_cur = 63;
        press(6, 14);
        chk("clamp_h", 32'(lh_val), 32'h23);
        press(6, 14);
        chk("clamp_m", 32'(lm_val), 32'h59);

        // Bounce shorter than the debounce window, then a long hold.
        repeat (3) tick(1'b1, 1'b0);
        repeat (12) tick(1'b1, 1'b1);
        chk("bounce", 32'(mode), 32'd0);
        press(50, 12);
        chk("hold50", 32'(mode), 32'd1);

        // Blink in SET_HOURS, then back to RUN.
        repeat (40) tick(1'b1, 1'b1);
        press(6, 14);
        press(6, 14);
        chk("blink_run", 32'(blink), 32'd0);

        // Reset while in SET_MINUTES aborts without a load.
        press(6, 14);
        press(6, 14);
        chk("in_setm", 32'(mode), 32'd2);
        lm_cyc = -1;
        tick(1'b0, 1'b1);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_run", 32'(run_en), 32'd1);
        repeat (10) tick(1'b1, 1'b1);
        chk("no_lm", 32'(lm_cyc), 32'hFFFF_FFFF);

        // Key held low through reset release.
        repeat (3) tick(1'b0, 1'b0);
        press(10, 12);
        chk("held_rst", 32'(mode), 32'd1);

        // Random key activity with bounces and changing switches.
        for (int i = 0; i < 60; i++) begin
            sw_cur = $urandom_range(0, 63);
            repeat ($urandom_range(1, 10)) tick(1'b1, 1'b0);
            repeat ($urandom_range(1, 12)) tick(1'b1, 1'b1);
        end
        repeat (20) tick(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable cycles for a key change to be accepted (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter BLINK_CYCLES, default 12500000, the half-period of Blink in clock cycles.
REQ-003 The block SHALL have port CLK_50_MHZ_GEN, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port Time_Set, input, 1 bit: raw asynchronous pushbutton, low = pressed.
REQ-006 The block SHALL have port SW, input, [9:4], 6 bits: unsigned binary set value.
REQ-007 The block SHALL have port Run_Enable, output, 1 bit: high = downstream time counters may count.
REQ-008 The block SHALL have port Set_Mode, output, 2 bits: 00 RUN, 01 SET_HOURS, 10 SET_MINUTES.
REQ-009 The block SHALL have port Load_Hours, output, 1 bit: one-cycle strobe to load the hour digits.
REQ-010 The block SHALL have port Load_Minutes, output, 1 bit: one-cycle strobe to load the minute digits.
REQ-011 The block SHALL have port Load_Tens, output, 4 bits: BCD tens digit of the load value.
REQ-012 The block SHALL have port Load_Ones, output, 4 bits: BCD ones digit of the load value.
REQ-013 The block SHALL have port Blink, output, 1 bit: display-blank request for the field being set.

Function
REQ-014 Time_Set SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 The debounced key SHALL change state only after the synchronized key differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match SHALL clear the count.
REQ-016 A press event SHALL be a one-cycle pulse on the debounced high-to-low transition only; release and continued holding SHALL generate no event.
REQ-017 The FSM SHALL advance on each press event RUN -> SET_HOURS -> SET_MINUTES -> RUN and SHALL otherwise hold state.
REQ-018 Leaving SET_HOURS SHALL assert Load_Hours for exactly one cycle with value min(SW, 23).
REQ-019 Leaving SET_MINUTES SHALL assert Load_Minutes for exactly one cycle with value min(SW, 59).
REQ-020 Leaving RUN SHALL assert no load strobe.
REQ-021 Load_Tens and Load_Ones SHALL equal value/10 and value%10 in the strobe cycle, registered together with the strobe, and SHALL hold until the next strobe.
REQ-022 Load_Hours and Load_Minutes SHALL never be high in the same cycle.
REQ-023 The load strobe and the state change SHALL appear in the same cycle, DEBOUNCE_CYCLES+3 cycles after the first clock edge sampling Time_Set low, provided the key stays low throughout.
REQ-024 Run_Enable SHALL be 1 only in RUN and SHALL go high in the same cycle as Load_Minutes.
REQ-025 Blink SHALL be 0 in RUN and SHALL start at 0 on entry to each SET state.
REQ-026 In each SET state, Blink SHALL toggle every BLINK_CYCLES cycles, with its counter cleared on state entry.
REQ-027 A low pulse shorter than DEBOUNCE_CYCLES SHALL produce no event and no state change.

Reset
REQ-028 While Reset = 0 at a clock edge, the block SHALL enter RUN.
REQ-029 Reset SHALL drive Run_Enable = 1, Set_Mode = 00, Load_Hours = Load_Minutes = 0, Load_Tens = Load_Ones = 0 and Blink = 0.
REQ-030 Reset SHALL clear the debounced key to released (1) and clear the debounce and blink counters.
REQ-031 Reset asserted mid-SET SHALL abort the set with no load strobe.
REQ-032 A key held low through reset release SHALL generate one press only after DEBOUNCE_CYCLES stable cycles.

Structure
REQ-033 A shared package SHALL hold the state enum (RUN, SET_HOURS, SET_MINUTES) and the constants MAX_HOURS = 23 and MAX_MINUTES = 59.
REQ-034 The synchronizer and debouncer SHALL be one sub-module, key_debounce, parameterized by DEBOUNCE_CYCLES, outputting the debounced level and the press pulse.
REQ-035 The clamp, BCD split, FSM and blink SHALL reside in time_set_ctrl.

Verification (bench uses DEBOUNCE_CYCLES=4, BLINK_CYCLES=8)
REQ-036 Reset, then idle 20 cycles -> Run_Enable = 1, Set_Mode = 00, no strobes, Blink = 0.
REQ-037 SW = 17, then press twice, then SW = 42, then press a third time -> Load_Hours one cycle with Tens/Ones = 1/7 exactly 7 cycles after the second press's first low sample; Load_Minutes with 4/2 on the third press; Run_Enable = 1 in the same cycle.
REQ-038 In SET_HOURS with SW = 63 -> Load_Tens/Ones = 2/3; in SET_MINUTES with SW = 63 -> 5/9.
REQ-039 Time_Set low for 3 cycles, then high (bounce) -> no event; key held low 50 cycles -> exactly one event.
REQ-040 In SET_HOURS, hold 40 cycles -> Blink toggles every 8 cycles starting at 0; after return to RUN, Blink = 0.
REQ-041 Reset asserted in SET_MINUTES -> next cycle RUN, Run_Enable = 1, no Load_Minutes pulse.
